// File: rtl/mult_div_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_pkg
// Shared definitions for the iterative multiply/divide unit: FSM state
// encoding, operation encodings and datapath/iteration constants.
// -----------------------------------------------------------------------------
package mult_div_pkg;

   localparam int WIDTH  = 32;
   localparam int N_ITER = 32;
   localparam int CNT_W  = 6;

   // Counter value seen on the final iteration edge (E32).
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mult_div.sv
// -----------------------------------------------------------------------------
// mult_div
// Iterative 32-bit signed multiply / divide unit.
//   MULT : signed radix-2 Booth, 32 steps, 65-bit accumulator {hi, lo, q-1}.
//   DIV  : restoring division on magnitudes, 32 steps, signs fixed at the end
//          (quotient truncates toward zero, remainder takes the sign of a).
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   start     in   operation request, honoured only in IDLE
//   op        in   0 = MULT, 1 = DIV, sampled with start
//   a, b      in   32-bit operands (rs, rt)
//   hi        out  MULT product[63:32] / DIV remainder
//   lo        out  MULT product[31:0]  / DIV quotient
//   busy      out  high while iterating (MULT or DIV state)
//   done      out  one-cycle pulse, hi/lo valid from this cycle on
//   div_zero  out  one-cycle pulse with done when DIV was issued with b == 0
// -----------------------------------------------------------------------------
module mult_div
   import mult_div_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   // Two's-complement magnitude; 0x80000000 maps to 2^31 read as unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                   input logic neg);
      return neg ? (~mag + 1'b1) : mag;
   endfunction

   // Control state
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             dz_q;
   logic             accept;
   logic             last_iter;

   // Datapath state (no reset needed: always loaded on accept)
   logic signed [WIDTH-1:0] mcand_q;
   logic [2*WIDTH:0]        acc_q;      // {hi[64:33], lo[32:1], q-1[0]}
   logic [WIDTH-1:0]        rem_q;
   logic [WIDTH-1:0]        quo_q;
   logic [WIDTH-1:0]        dvsr_q;
   logic                    q_neg_q;
   logic                    r_neg_q;

   // Step results
   logic signed [WIDTH:0]   hi_ext;
   logic signed [WIDTH:0]   mcand_ext;
   logic signed [WIDTH:0]   booth_sum;
   logic [2*WIDTH:0]        booth_next;
   logic [WIDTH:0]          rem_shift;
   logic                    rem_ge;
   logic [WIDTH-1:0]        rem_next;
   logic [WIDTH-1:0]        quo_next;
   logic [WIDTH-1:0]        q_final;
   logic [WIDTH-1:0]        r_final;

   assign accept    = (state_q == IDLE) && start;
   assign last_iter = (cnt_q == CNT_LAST);
   assign div_zero  = done && dz_q;

   // Booth step. The add is done one bit wider than hi so that the
   // extreme operand -2^31 cannot overflow; the extra sign bit is exactly
   // what the arithmetic right shift moves into hi[31].
   always_comb begin
      hi_ext    = $signed({acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]});
      mcand_ext = $signed({mcand_q[WIDTH-1], mcand_q});
      booth_sum = hi_ext;
      case (acc_q[1:0])
         2'b01:   booth_sum = hi_ext + mcand_ext;
         2'b10:   booth_sum = hi_ext - mcand_ext;
         default: booth_sum = hi_ext;
      endcase
      // {sum, lo} shifted right by one drops q-1 and keeps the 65-bit layout.
      booth_next = {booth_sum, acc_q[WIDTH:1]};
   end

   // Restoring division step. The partial remainder stays below the
   // divisor (<= 2^31), so it always fits back into 32 bits.
   always_comb begin
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      rem_ge    = (rem_shift >= {1'b0, dvsr_q});
      rem_next  = rem_ge ? WIDTH'(rem_shift - {1'b0, dvsr_q})
                         : rem_shift[WIDTH-1:0];
      quo_next  = {quo_q[WIDTH-2:0], rem_ge};
      q_final   = apply_sign(quo_next, q_neg_q);
      r_final   = apply_sign(rem_next, r_neg_q);
   end

   // Next-state and status outputs
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = (op == OP_DIV) ? DIV : MULT;
         end
         MULT: begin
            busy = 1'b1;
            if (last_iter) state_d = DONE;
         end
         DIV: begin
            busy = 1'b1;
            // A zero divisor leaves after the first edge without iterating.
            if (dz_q || last_iter) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers and the architectural result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q <= '0;
            dz_q  <= (op == OP_DIV) && (b == '0);
         end else if (busy && !last_iter) begin
            cnt_q <= cnt_q + 1'b1;
         end
         // hi/lo change only on the edge that enters DONE with a real result.
         if (state_q == MULT && last_iter) begin
            {hi, lo} <= booth_next[2*WIDTH:1];
         end else if (state_q == DIV && last_iter && !dz_q) begin
            hi <= r_final;
            lo <= q_final;
         end
      end
   end

   // Iteration datapath
   always_ff @(posedge clk) begin
      if (accept) begin
         mcand_q <= a;
         acc_q   <= {{WIDTH{1'b0}}, b, 1'b0};
         rem_q   <= '0;
         quo_q   <= magnitude(a);
         dvsr_q  <= magnitude(b);
         q_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
         r_neg_q <= a[WIDTH-1];
      end else if (state_q == MULT) begin
         acc_q <= booth_next;
      end else if (state_q == DIV) begin
         rem_q <= rem_next;
         quo_q <= quo_next;
      end
   end

endmodule

// File: tb/tb_mult_div.sv
module tb_mult_div;
   import mult_div_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_zero;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference architectural result registers
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mult_div dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Behavioural model: plain 64-bit signed arithmetic.
   task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y,
                        output bit dz);
      longint sx;
      longint sy;
      longint p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      dz = 1'b0;
      if (o == OP_MULT) begin
         p    = sx * sy;
         m_hi = p[63:32];
         m_lo = p[31:0];
      end else if (y == 32'd0) begin
         dz = 1'b1;
      end else begin
         m_lo = 32'(sx / sy);
         m_hi = 32'(sx % sy);
      end
   endtask

   task automatic run_op(input string tag, input logic o, input logic [31:0] x,
                         input logic [31:0] y);
      bit dz;
      int cyc;
      int exp_cyc;
      model(o, x, y, dz);
      exp_cyc = dz ? 1 : N_ITER;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);                       // E0 has accepted
      start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
      check({tag, "/busy_e0"}, busy, 1);
      cyc = 0;
      while (!done && cyc < 64) begin
         @(negedge clk);
         cyc++;
         // A start during iteration must not be queued.
         if (cyc == 4) begin start = 1'b1; op = 1'($urandom); end
         if (cyc == 5) start = 1'b0;
      end
      start = 1'b0;
      check({tag, "/latency"}, cyc, exp_cyc);
      check({tag, "/hi"}, hi, m_hi);
      check({tag, "/lo"}, lo, m_lo);
      check({tag, "/div_zero"}, div_zero, dz);
      check({tag, "/busy_done"}, busy, 0);
      // Start while in DONE must also be ignored.
      start = 1'b1; op = 1'($urandom);
      @(negedge clk);
      start = 1'b0;
      check({tag, "/done_pulse"}, done, 0);
      check({tag, "/no_accept"}, busy, 0);
      check({tag, "/hold_hi"}, hi, m_hi);
   endtask

   initial begin
      logic        ro;
      logic [31:0] rx;
      logic [31:0] ry;
      int          cyc;

      reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("rst/hi", hi, 0);
      check("rst/lo", lo, 0);
      check("rst/busy", busy, 0);
      check("rst/done", done, 0);
      check("rst/div_zero", div_zero, 0);
      check("rst/state", dut.state_q, IDLE);
      check("rst/cnt", dut.cnt_q, 0);
      reset = 1'b1;

      run_op("mul_7x-3", OP_MULT, 32'd7, 32'hFFFFFFFD);
      check("mul_7x-3/hi_const", hi, 32'hFFFFFFFF);
      check("mul_7x-3/lo_const", lo, 32'hFFFFFFEB);

      run_op("mul_max", OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF);
      check("mul_max/hi_const", hi, 32'h3FFFFFFF);
      check("mul_max/lo_const", lo, 32'h00000001);

      run_op("div_-7/2", OP_DIV, 32'hFFFFFFF9, 32'd2);
      check("div_-7/2/lo_const", lo, 32'hFFFFFFFD);
      check("div_-7/2/hi_const", hi, 32'hFFFFFFFF);

      run_op("div_setup", OP_DIV, 32'h451, 32'h20);
      check("div_setup/hi_const", hi, 32'h11);
      check("div_setup/lo_const", lo, 32'h22);

      run_op("div_zero", OP_DIV, 32'd5, 32'd0);
      check("div_zero/hi_const", hi, 32'h11);
      check("div_zero/lo_const", lo, 32'h22);

      run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      check("div_ovf/lo_const", lo, 32'h80000000);
      check("div_ovf/hi_const", hi, 32'h0);

      run_op("mul_minmin", OP_MULT, 32'h80000000, 32'h80000000);
      run_op("mul_minx1", OP_MULT, 32'h80000000, 32'h7FFFFFFF);

      for (int i = 0; i < 40; i++) begin
         ro = 1'($urandom);
         rx = $urandom;
         ry = $urandom;
         case ($urandom_range(0, 7))
            0: ry = 32'd0;
            1: ry = 32'hFFFFFFFF;
            2: rx = 32'h80000000;
            3: ry = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op("rand", ro, rx, ry);
      end

      // Abort mid-operation: second start at iteration 5, reset at iteration 10.
      @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'd123; b = 32'd456;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (cyc == 5) begin start = 1'b1; op = OP_DIV; a = $urandom; b = $urandom; end
         if (cyc == 6) begin
            start = 1'b0;
            check("abort/busy_it6", busy, 1);
            check("abort/state_it6", dut.state_q, MULT);
         end
      end
      reset = 1'b0;
      #1;
      m_hi = '0;
      m_lo = '0;
      check("abort/busy", busy, 0);
      check("abort/done", done, 0);
      check("abort/hi", hi, 0);
      check("abort/lo", lo, 0);
      check("abort/state", dut.state_q, IDLE);
      @(negedge clk);
      reset = 1'b1;
      run_op("post_rst", OP_MULT, 32'hFFFF0001, 32'd77);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
